mips_alu: RTL and testbench



---
 rtl/mips_alu_pkg.sv | 118 +++++++++++
 rtl/mips_alu_shifter.sv | 22 ++
 rtl/mips_alu.sv | 121 ++++++++++++
 tb/tb_mips_alu.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared encodings, flag indices and the instruction decoder for the registered MIPS-I ALU.
// The optional illegal-encoding output is enabled with MIPS_ALU_ILLEGAL_EN (see mips_alu).
package mips_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int unsigned FLAG_ZERO = 2;
  localparam int unsigned FLAG_OVF  = 1;
  localparam int unsigned FLAG_NEG  = 0;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluXor,
    AluNor,
    AluSlt,
    AluSltu,
    AluShift
  } alu_op_e;

  typedef enum logic [1:0] {
    OpbReg,
    OpbSimm,
    OpbZimm
  } opb_sel_e;

  typedef struct packed {
    alu_op_e  op;
    opb_sel_e opb;
    logic     ovf_en;
    logic     shift_var;
    logic     shift_right;
    logic     shift_arith;
    logic     illegal;
  } alu_ctrl_t;

  function automatic alu_ctrl_t alu_decode(input logic [5:0] opcode, input logic [5:0] funct);
    alu_ctrl_t c;
    c.op          = AluAdd;
    c.opb         = OpbReg;
    c.ovf_en      = 1'b0;
    c.shift_var   = 1'b0;
    c.shift_right = 1'b0;
    c.shift_arith = 1'b0;
    c.illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin c.op = AluAdd; c.ovf_en = 1'b1; end
          FN_ADDU: c.op = AluAdd;
          FN_SUB:  begin c.op = AluSub; c.ovf_en = 1'b1; end
          FN_SUBU: c.op = AluSub;
          FN_AND:  c.op = AluAnd;
          FN_OR:   c.op = AluOr;
          FN_XOR:  c.op = AluXor;
          FN_NOR:  c.op = AluNor;
          FN_SLT:  c.op = AluSlt;
          FN_SLTU: c.op = AluSltu;
          FN_SLL:  c.op = AluShift;
          FN_SRL:  begin c.op = AluShift; c.shift_right = 1'b1; end
          FN_SRA:  begin c.op = AluShift; c.shift_right = 1'b1; c.shift_arith = 1'b1; end
          FN_SLLV: begin c.op = AluShift; c.shift_var = 1'b1; end
          FN_SRLV: begin c.op = AluShift; c.shift_var = 1'b1; c.shift_right = 1'b1; end
          FN_SRAV: begin
            c.op          = AluShift;
            c.shift_var   = 1'b1;
            c.shift_right = 1'b1;
            c.shift_arith = 1'b1;
          end
          default: c.illegal = 1'b1;
        endcase
      end
      OP_ADDI:      begin c.op = AluAdd; c.opb = OpbSimm; c.ovf_en = 1'b1; end
      OP_ADDIU:     begin c.op = AluAdd; c.opb = OpbSimm; end
      OP_SLTI:      begin c.op = AluSlt; c.opb = OpbSimm; end
      // sltiu compares against the sign-extended immediate as an unsigned value
      OP_SLTIU:     begin c.op = AluSltu; c.opb = OpbSimm; end
      OP_ANDI:      begin c.op = AluAnd; c.opb = OpbZimm; end
      OP_ORI:       begin c.op = AluOr; c.opb = OpbZimm; end
      OP_XORI:      begin c.op = AluXor; c.opb = OpbZimm; end
      OP_LW, OP_SW: begin c.op = AluAdd; c.opb = OpbSimm; end
      OP_BEQ, OP_BNE: c.op = AluSub;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_alu_shifter.sv
// Combinational 32-bit barrel shifter shared by all MIPS shift operations.
// dir: 0 = left, 1 = right; arith selects sign replication on right shifts.
module mips_alu_shifter (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  logic        dir,
  input  logic        arith,
  output logic [31:0] result
);

  always_comb begin
    result = data << amount;
    if (dir) begin
      if (arith) begin
        result = $unsigned($signed(data) >>> amount);
      end else begin
        result = data >> amount;
      end
    end
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS-I EX-stage ALU: decodes the instruction word, computes result and flags.
// Define MIPS_ALU_ILLEGAL_EN to add the registered 'illegal' output for unsupported encodings.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
`ifdef MIPS_ALU_ILLEGAL_EN
  output logic        illegal,
`endif
  output logic [31:0] final_result,
  output logic [2:0]  flag
);

  alu_ctrl_t   ctrl;
  logic [31:0] simm, zimm, op_b;
  logic [31:0] sum, diff, shift_res;
  logic [4:0]  shift_amt;
  logic        lt_signed, lt_unsigned;
  logic        lt, ovf;
  logic [31:0] alu_res;
  logic [31:0] final_result_d, final_result_q;
  logic [2:0]  flag_d, flag_q;

  assign ctrl = alu_decode(instruction[31:26], instruction[5:0]);
  assign simm = {{16{instruction[15]}}, instruction[15:0]};
  assign zimm = {16'h0000, instruction[15:0]};

  always_comb begin
    op_b = reg2;
    unique case (ctrl.opb)
      OpbSimm: op_b = simm;
      OpbZimm: op_b = zimm;
      default: op_b = reg2;
    endcase
  end

  assign sum         = reg1 + op_b;
  assign diff        = reg1 - op_b;
  assign lt_signed   = $signed(reg1) < $signed(op_b);
  assign lt_unsigned = reg1 < op_b;
  assign shift_amt   = ctrl.shift_var ? reg1[4:0] : instruction[10:6];

  mips_alu_shifter u_shifter (
    .data   (reg2),
    .amount (shift_amt),
    .dir    (ctrl.shift_right),
    .arith  (ctrl.shift_arith),
    .result (shift_res)
  );

  always_comb begin
    alu_res = '0;
    lt      = 1'b0;
    ovf     = 1'b0;
    unique case (ctrl.op)
      AluAdd: begin
        alu_res = sum;
        ovf     = ctrl.ovf_en & (reg1[31] == op_b[31]) & (sum[31] != reg1[31]);
      end
      AluSub: begin
        alu_res = diff;
        ovf     = ctrl.ovf_en & (reg1[31] != op_b[31]) & (diff[31] != reg1[31]);
      end
      AluAnd:   alu_res = reg1 & op_b;
      AluOr:    alu_res = reg1 | op_b;
      AluXor:   alu_res = reg1 ^ op_b;
      AluNor:   alu_res = ~(reg1 | op_b);
      AluSlt:   begin lt = lt_signed; alu_res = {31'd0, lt_signed}; end
      AluSltu:  begin lt = lt_unsigned; alu_res = {31'd0, lt_unsigned}; end
      AluShift: alu_res = shift_res;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    final_result_d = alu_res;
    flag_d         = '0;
    flag_d[FLAG_ZERO] = (alu_res == 32'd0);
    flag_d[FLAG_OVF]  = ovf;
    flag_d[FLAG_NEG]  = ((ctrl.op == AluSlt) || (ctrl.op == AluSltu)) ? lt : alu_res[31];
    // Unsupported encodings must not raise zero even though the result is 0
    if (ctrl.illegal) begin
      final_result_d = '0;
      flag_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      final_result_q <= '0;
      flag_q         <= '0;
    end else begin
      final_result_q <= final_result_d;
      flag_q         <= flag_d;
    end
  end

  assign final_result = final_result_q;
  assign flag         = flag_q;

`ifdef MIPS_ALU_ILLEGAL_EN
  logic illegal_d, illegal_q;

  assign illegal_d = ctrl.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: expected results queued at drive time, popped after each edge.
module tb_mips_alu;
  import mips_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [31:0] final_result;
  logic [2:0]  flag;
  logic        illegal;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flg;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  mips_alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instruction  (instruction),
    .reg1         (reg1),
    .reg2         (reg2),
`ifdef MIPS_ALU_ILLEGAL_EN
    .illegal      (illegal),
`endif
    .final_result (final_result),
    .flag         (flag)
  );

`ifndef MIPS_ALU_ILLEGAL_EN
  assign illegal = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
    return {OP_RTYPE, 5'd1, 5'd2, 5'd3, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, final_result, e.res);
      chk({tag, "_flag"}, {29'd0, flag}, {29'd0, e.flg});
`ifdef MIPS_ALU_ILLEGAL_EN
      chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e.ill});
`endif
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] res, input logic [2:0] flg,
                      input logic ill, input logic rel);
    @(negedge clk);
    instruction = ins;
    reg1        = r1;
    reg2        = r2;
    if (rel) rst_n = 1'b1;
    sb.push_back('{res: res, flg: flg, ill: ill});
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b1;
    instruction = rt(FN_ADD, 5'd0);
    reg1        = 32'h1234_5678;
    reg2        = 32'h1111_1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_result", final_result, 32'd0);
    chk("reset_async_flag", {29'd0, flag}, 32'd0);
    chk("reset_async_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_result", final_result, 32'd0);
    chk("reset_held_flag", {29'd0, flag}, 32'd0);

    // Release coincides with new inputs; the first edge must register them
    step("rel_add", rt(FN_ADD, 5'd0), 32'd3, 32'd4, 32'd7, 3'b000, 1'b0, 1'b1);

    step("add_ovf_pos", rt(FN_ADD, 5'd0), 32'h8000_0002, 32'hBFFF_FFFE,
         32'h4000_0000, 3'b010, 1'b0, 1'b0);
    step("add_ovf_neg", rt(FN_ADD, 5'd0), 32'h4000_0002, 32'h7FFF_FFFE,
         32'hC000_0000, 3'b011, 1'b0, 1'b0);
    step("addu_no_ovf", rt(FN_ADDU, 5'd0), 32'h8000_0002, 32'hBFFF_FFFE,
         32'h4000_0000, 3'b000, 1'b0, 1'b0);
    step("add_zero", rt(FN_ADD, 5'd0), 32'h0000_0001, 32'hFFFF_FFFF,
         32'h0000_0000, 3'b100, 1'b0, 1'b0);
    step("sub_ovf", rt(FN_SUB, 5'd0), 32'h7FFE_0002, 32'h8003_CC0E,
         32'hFFFA_33F4, 3'b011, 1'b0, 1'b0);
    step("subu", rt(FN_SUBU, 5'd0), 32'h7FFE_0002, 32'h8003_CC0E,
         32'hFFFA_33F4, 3'b001, 1'b0, 1'b0);
    step("and_zero", rt(FN_AND, 5'd0), 32'hF0F0_0000, 32'h0F0F_00FF,
         32'h0000_0000, 3'b100, 1'b0, 1'b0);
    step("or", rt(FN_OR, 5'd0), 32'hF0F0_0000, 32'h0F0F_00FF,
         32'hFFFF_00FF, 3'b001, 1'b0, 1'b0);
    step("xor", rt(FN_XOR, 5'd0), 32'hF0F0_00F0, 32'h0F0F_00FF,
         32'hFFFF_000F, 3'b001, 1'b0, 1'b0);
    step("nor", rt(FN_NOR, 5'd0), 32'hF0F0_0000, 32'h0F0F_00FF,
         32'h0000_FF00, 3'b000, 1'b0, 1'b0);
    step("slt_true", rt(FN_SLT, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001,
         32'h0000_0001, 3'b001, 1'b0, 1'b0);
    step("sltu_false", rt(FN_SLTU, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001,
         32'h0000_0000, 3'b100, 1'b0, 1'b0);
    step("sll", rt(FN_SLL, 5'd3), 32'h0000_0000, 32'hB00F_0018,
         32'h8078_00C0, 3'b001, 1'b0, 1'b0);
    step("srl", rt(FN_SRL, 5'd4), 32'h0000_0000, 32'h8000_0000,
         32'h0800_0000, 3'b000, 1'b0, 1'b0);
    step("sra", rt(FN_SRA, 5'd4), 32'h0000_0000, 32'h8000_0000,
         32'hF800_0000, 3'b001, 1'b0, 1'b0);
    step("sllv_mask", rt(FN_SLLV, 5'd7), 32'h0000_0021, 32'h0000_0001,
         32'h0000_0002, 3'b000, 1'b0, 1'b0);
    step("srlv", rt(FN_SRLV, 5'd0), 32'h0000_001F, 32'h8000_0000,
         32'h0000_0001, 3'b000, 1'b0, 1'b0);
    step("srav", rt(FN_SRAV, 5'd0), 32'h0000_0004, 32'h8000_0000,
         32'hF800_0000, 3'b001, 1'b0, 1'b0);
    step("addi_ovf", it(OP_ADDI, 16'h0001), 32'h7FFF_FFFF, 32'h0,
         32'h8000_0000, 3'b011, 1'b0, 1'b0);
    step("addiu", it(OP_ADDIU, 16'h0001), 32'h7FFF_FFFF, 32'h0,
         32'h8000_0000, 3'b001, 1'b0, 1'b0);
    step("slti_false", it(OP_SLTI, 16'hFFFF), 32'h0000_0005, 32'h0,
         32'h0000_0000, 3'b100, 1'b0, 1'b0);
    step("sltiu", it(OP_SLTIU, 16'h8022), 32'h0037_6022, 32'h0,
         32'h0000_0001, 3'b001, 1'b0, 1'b0);
    step("andi", it(OP_ANDI, 16'hF226), 32'h0000_EC66, 32'h0,
         32'h0000_E026, 3'b000, 1'b0, 1'b0);
    step("ori_zext", it(OP_ORI, 16'h8001), 32'h1234_0000, 32'h0,
         32'h1234_8001, 3'b000, 1'b0, 1'b0);
    step("xori", it(OP_XORI, 16'hFFFF), 32'hFFFF_0000, 32'h0,
         32'hFFFF_FFFF, 3'b001, 1'b0, 1'b0);
    step("lw_addr", it(OP_LW, 16'hFFFC), 32'h0000_1000, 32'h0,
         32'h0000_0FFC, 3'b000, 1'b0, 1'b0);
    step("sw_addr", it(OP_SW, 16'h0004), 32'h0000_0000, 32'h0,
         32'h0000_0004, 3'b000, 1'b0, 1'b0);
    step("beq_equal", it(OP_BEQ, 16'h0010), 32'h8037_6002, 32'h8037_6002,
         32'h0000_0000, 3'b100, 1'b0, 1'b0);
    step("bne_differ", it(OP_BNE, 16'h0010), 32'h0837_6002, 32'h8235_CC0F,
         32'h8601_93F3, 3'b001, 1'b0, 1'b0);
    step("bad_funct", rt(6'h3F, 5'd0), 32'h1234_5678, 32'h1234_5678,
         32'h0000_0000, 3'b000, 1'b1, 1'b0);
    step("bad_opcode", it(6'h3F, 16'h0000), 32'h0000_0001, 32'h0000_0001,
         32'h0000_0000, 3'b000, 1'b1, 1'b0);
    step("after_bad", rt(FN_ADDU, 5'd0), 32'h0000_0001, 32'h0000_0001,
         32'h0000_0002, 3'b000, 1'b0, 1'b0);

    // Mid-cycle reset must clear outputs without waiting for an edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_result", final_result, 32'd0);
    chk("reset_mid_flag", {29'd0, flag}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mid_held_result", final_result, 32'd0);
    step("rel_sub", rt(FN_SUBU, 5'd0), 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b001, 1'b0, 1'b1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
